// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with per-frame snapshot and blanking.
// Define LEADING_ZERO_BLANK_EN to suppress a leading zero on the minutes-tens digit.
module seg7_scan_driver #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] dvseconds_count,
  input  logic [3:0] chucseconds_count,
  input  logic [3:0] dvminutes_count,
  input  logic [3:0] chucminutes_count,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HALF     = CLK_HZ / 2;
  localparam int BLK_W    = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(HALF - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   snap_q, snap_d;
  logic [BLK_W-1:0]  bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;
  logic              frame_q, frame_d;

  logic              scan_tick;
  logic              blank;
  logic              lz;
  logic [3:0]        cur;

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign scan_tick = (div_q == DIV_MAX);
  assign blank     = (BLANK_CYC > 0) && (int'(div_q) < BLANK_CYC);
  assign cur       = snap_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
  assign lz = (idx_q == 2'd3) && (snap_q[3] == 4'd0);
`else
  assign lz = 1'b0;
`endif

  always_comb begin
    div_d   = scan_tick ? '0 : div_q + 1'b1;
    idx_d   = scan_tick ? idx_q + 2'd1 : idx_q;
    snap_d  = snap_q;
    frame_d = scan_tick && (idx_q == 2'd3);
    if (frame_d) begin
      snap_d = {chucminutes_count, dvminutes_count,
                chucseconds_count, dvseconds_count};
    end
  end

  // Phase restarts high whenever the counter is paused.
  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b1;
    if (run) begin
      if (bcnt_q == BLK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_comb begin
    seg_d = seg_dec(cur);
    an_d  = 4'hF;
    if (!blank && !lz) begin
      case (idx_q)
        2'd0:    an_d = 4'b1110;
        2'd1:    an_d = 4'b1101;
        2'd2:    an_d = 4'b1011;
        default: an_d = 4'b0111;
      endcase
    end
    dp_d = ~(!blank && (idx_q == 2'd2) && phase_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'hF;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at CLK_HZ=64, SCAN_HZ=16, BLANK_CYC=1.
// Expected outputs are derived from the edge count since reset release.
module tb_seg7_scan_driver;

  localparam int CLK_HZ    = 64;
  localparam int SCAN_HZ   = 16;
  localparam int BLANK_CYC = 1;
  localparam int SDIV      = CLK_HZ / SCAN_HZ;
  localparam int HALF      = CLK_HZ / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] dvs = '0, chs = '0, dvm = '0, chm = '0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_tick;

  seg7_scan_driver #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .dvseconds_count(dvs), .chucseconds_count(chs),
    .dvminutes_count(dvm), .chucminutes_count(chm),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  exp_t       sb_q[$];
  int         n_run = 0;
  int         n_fail = 0;
  int         e = 0;
  int         runlen = 0;
  logic [3:0] m_snap [4] = '{default: 4'd0};

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: predicts the registered outputs produced by each clock edge.
  always @(posedge clk) begin
    if (!reset) begin : model
      int         t, dv, ix;
      logic       blk, ph;
      logic [3:0] one;
      exp_t       x;
      t   = e;
      e   = e + 1;
      dv  = t % SDIV;
      ix  = (t / SDIV) % 4;
      blk = dv < BLANK_CYC;
      ph  = ((runlen / HALF) % 2) == 0;
      one = 4'b0001;
      x.an = blk ? 4'hF : ~(one << ix);
`ifdef LEADING_ZERO_BLANK_EN
      if (ix == 3 && m_snap[3] == 4'd0) x.an = 4'hF;
`endif
      x.seg = dec(m_snap[ix]);
      x.dp  = !(!blk && ix == 2 && ph);
      x.ft  = (dv == SDIV - 1) && (ix == 3);
      sb_q.push_back(x);
      if (x.ft) begin
        m_snap[0] = dvs;
        m_snap[1] = chs;
        m_snap[2] = dvm;
        m_snap[3] = chm;
      end
      runlen = run ? runlen + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && sb_q.size() > 0) begin : scoreboard
      exp_t x;
      x = sb_q.pop_front();
      chk("an_n", 16'(an_n), 16'(x.an));
      if (x.an != 4'hF) chk("seg_n", 16'(seg_n), 16'(x.seg));
      chk("dp_n", 16'(dp_n), 16'(x.dp));
      chk("frame_tick", 16'(frame_tick), 16'(x.ft));
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg"}, 16'(seg_n), 16'h7F);
    chk({tag, "_an"}, 16'(an_n), 16'hF);
    chk({tag, "_dp"}, 16'(dp_n), 16'h1);
    chk({tag, "_ft"}, 16'(frame_tick), 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    e = 0;
    runlen = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    #1 check_reset_vals("rst_async");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    #1 reset = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d);
    @(negedge clk);
    #1;
    dvs = a; chs = b; dvm = c; chm = d;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (frame_tick !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wait", 16'(k < 40), 16'h1);
  endtask

  initial begin
    int cnt;
    do_reset();
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (40) @(negedge clk);

    repeat (6) @(negedge clk);
    set_in(4'd5, 4'd6, 4'd7, 4'd8);
    wait_frame();
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) cnt++;
    end
    chk("frame_rate", 16'(cnt), 16'd2);

    @(negedge clk);
    #1 run = 1'b1;
    repeat (140) @(negedge clk);
    #1 run = 1'b0;
    repeat (24) @(negedge clk);

    set_in(4'hC, 4'hA, 4'd9, 4'd0);
    repeat (40) @(negedge clk);
    set_in(4'hF, 4'd3, 4'd0, 4'd0);
    repeat (40) @(negedge clk);

    set_in(4'd2, 4'd4, 4'd6, 4'd8);
    repeat (7) @(negedge clk);
    do_reset();
    #1 run = 1'b1;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
